// File: rtl/instruction_fetch_controller_if.sv
// rtl/instruction_fetch_controller_if.sv - memory, decode and control bundle of the instruction fetch controller
interface instruction_fetch_controller_if;
  logic [15:0] MemAddr;
  logic        MemRdEn;
  logic [7:0]  MemRdData;
  logic [15:0] Instruction;
  logic [15:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady;
  logic        Redirect;
  logic [15:0] RedirectPC;
  logic        Halt;
  logic        Fault;

  modport master (
    output MemAddr, MemRdEn, Instruction, InstrPC, InstrValid, Fault,
    input  MemRdData, InstrReady, Redirect, RedirectPC, Halt
  );

  modport slave (
    input  MemAddr, MemRdEn, Instruction, InstrPC, InstrValid, Fault,
    output MemRdData, InstrReady, Redirect, RedirectPC, Halt
  );
endinterface

// File: rtl/instruction_fetch_controller.sv
// rtl/instruction_fetch_controller.sv - two-byte big-endian instruction fetch FSM; optional IFETCH_BOUND_CHECK_EN range check
module instruction_fetch_controller #(
  parameter int unsigned MEM_BYTES = 128,
  parameter logic [15:0] RESET_PC  = 16'h0000
) (
  input logic Clock,
  input logic ResetN,
  instruction_fetch_controller_if.master bus
);

  typedef enum logic [2:0] {IDLE, HI, LO, CAP, OUT, HALTED, FAULT} state_t;

`ifdef IFETCH_BOUND_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif
  // Highest PC whose two bytes both lie inside the memory.
  localparam int unsigned LAST_PC = MEM_BYTES - 2;

  state_t      state, state_nxt;
  logic [15:0] pc;
  logic [7:0]  hi_byte;
  logic [15:0] instr_q;
  logic [15:0] instr_pc_q;
  logic        oob;
  logic        rd_en;
  logic        valid;
  logic [15:0] addr;
  logic [15:0] redirect_target;

  // Fetch PC beyond the memory; folds to 0 when the range check is not built.
  assign oob             = CHECK_EN && (32'(pc) > LAST_PC);
  assign redirect_target = bus.RedirectPC & 16'hFFFE;

  // State register.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state; a redirect overrides everything, including a pending handshake.
  always_comb begin
    state_nxt = state;
    if (bus.Redirect) begin
      state_nxt = (state == HALTED || bus.Halt) ? HALTED : HI;
    end else begin
      case (state)
        IDLE:    state_nxt = bus.Halt ? HALTED : HI;
        HI:      state_nxt = oob ? FAULT : LO;
        LO:      state_nxt = CAP;
        CAP:     state_nxt = OUT;
        OUT:     if (bus.InstrReady) state_nxt = bus.Halt ? HALTED : HI;
        HALTED:  if (!bus.Halt) state_nxt = HI;
        FAULT:   state_nxt = FAULT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Memory strobe/address and decode valid as functions of the state.
  always_comb begin
    rd_en = 1'b0;
    valid = 1'b0;
    addr  = pc;
    case (state)
      HI:      rd_en = !oob;
      LO:      begin rd_en = 1'b1; addr = pc + 16'd1; end
      OUT:     valid = 1'b1;
      default: ;
    endcase
  end

  // PC, high-byte capture and the held instruction/PC pair.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      pc         <= RESET_PC;
      hi_byte    <= 8'h00;
      instr_q    <= 16'h0000;
      instr_pc_q <= 16'h0000;
    end else begin
      if (bus.Redirect)                        pc <= redirect_target;
      else if (state == OUT && bus.InstrReady) pc <= pc + 16'd2;
      if (state == LO) hi_byte <= bus.MemRdData;
      if (state == CAP) begin
        instr_q    <= {hi_byte, bus.MemRdData};
        instr_pc_q <= pc;
      end
    end
  end

  assign bus.MemAddr     = addr;
  assign bus.MemRdEn     = rd_en;
  assign bus.InstrValid  = valid;
  assign bus.Instruction = instr_q;
  assign bus.InstrPC     = instr_pc_q;
  assign bus.Fault       = CHECK_EN && (state == FAULT);

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// tb/tb_instruction_fetch_controller.sv - vector table, corner sequences and random run against a fetch-stream model
module tb_instruction_fetch_controller;

  logic Clock = 1'b0;
  logic ResetN;
  always #5 Clock = ~Clock;

  instruction_fetch_controller_if bus();

  instruction_fetch_controller #(.MEM_BYTES(128), .RESET_PC(16'h0000)) dut (
    .Clock (Clock),
    .ResetN(ResetN),
    .bus   (bus)
  );

  logic [7:0] mem [0:255];
  logic [7:0] rdata;
  always @(posedge Clock) if (bus.MemRdEn) rdata <= mem[bus.MemAddr[7:0]];
  assign bus.MemRdData = rdata;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ready, redir;
    logic [15:0] rpc;
    logic        halt, rden;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] instr, ipc;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic rd, input logic [15:0] rpc, input logic h,
                     input logic en, input logic [15:0] a, input logic v,
                     input logic [15:0] ins, input logic [15:0] ipc);
    tbl.push_back('{r, rd, rpc, h, en, a, v, ins, ipc});
  endtask

  function automatic logic [15:0] word_at(input logic [15:0] a);
    logic [15:0] b;
    b = a + 16'd1;
    return {mem[a[7:0]], mem[b[7:0]]};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp_pc, prev_instr, prev_ipc, nx;
    logic        halted, after_redir, hold, r, rd, h, hs, ok;
    logic [15:0] rpc;
    int          n_hs;

    for (int a = 0; a < 256; a++) mem[a] = 8'(a + 16);
    mem[0] = 8'h12;
    mem[1] = 8'h34;

    // rdy red rpc   hlt  en addr   vld instr    ipc
    add(1, 0, 16'h0, 0,   0, 16'h0000, 0, 16'h0000, 16'h0000);
    add(1, 0, 16'h0, 0,   1, 16'h0000, 0, 16'h0000, 16'h0000);
    add(1, 0, 16'h0, 0,   1, 16'h0001, 0, 16'h0000, 16'h0000);
    add(1, 0, 16'h0, 0,   0, 16'h0000, 0, 16'h0000, 16'h0000);
    add(1, 0, 16'h0, 0,   0, 16'h0000, 1, 16'h1234, 16'h0000);
    add(1, 0, 16'h0, 0,   1, 16'h0002, 0, 16'h1234, 16'h0000);
    add(1, 0, 16'h0, 0,   1, 16'h0003, 0, 16'h1234, 16'h0000);
    add(1, 0, 16'h0, 0,   0, 16'h0002, 0, 16'h1234, 16'h0000);
    for (int k = 0; k < 5; k++)
      add(0, 0, 16'h0, 0, 0, 16'h0002, 1, 16'h1213, 16'h0002);
    add(1, 0, 16'h0, 0,   0, 16'h0002, 1, 16'h1213, 16'h0002);
    add(1, 0, 16'h0, 0,   1, 16'h0004, 0, 16'h1213, 16'h0002);
    add(1, 1, 16'h0011, 0, 1, 16'h0005, 0, 16'h1213, 16'h0002);
    add(1, 0, 16'h0, 0,   1, 16'h0010, 0, 16'h1213, 16'h0002);
    add(1, 0, 16'h0, 0,   1, 16'h0011, 0, 16'h1213, 16'h0002);
    add(1, 0, 16'h0, 0,   0, 16'h0010, 0, 16'h1213, 16'h0002);
    add(1, 0, 16'h0, 1,   0, 16'h0010, 1, 16'h2021, 16'h0010);
    add(1, 0, 16'h0, 1,   0, 16'h0012, 0, 16'h2021, 16'h0010);
    add(1, 0, 16'h0, 1,   0, 16'h0012, 0, 16'h2021, 16'h0010);
    add(1, 0, 16'h0, 0,   0, 16'h0012, 0, 16'h2021, 16'h0010);
    add(1, 0, 16'h0, 0,   1, 16'h0012, 0, 16'h2021, 16'h0010);
    add(1, 0, 16'h0, 0,   1, 16'h0013, 0, 16'h2021, 16'h0010);
    add(1, 0, 16'h0, 0,   0, 16'h0012, 0, 16'h2021, 16'h0010);
    add(1, 1, 16'h0004, 0, 0, 16'h0012, 1, 16'h2223, 16'h0012);
    add(1, 0, 16'h0, 0,   1, 16'h0004, 0, 16'h2223, 16'h0012);
    add(1, 0, 16'h0, 0,   1, 16'h0005, 0, 16'h2223, 16'h0012);
    add(1, 0, 16'h0, 0,   0, 16'h0004, 0, 16'h2223, 16'h0012);
    add(1, 0, 16'h0, 0,   0, 16'h0004, 1, 16'h1415, 16'h0004);
    add(1, 0, 16'h0, 0,   1, 16'h0006, 0, 16'h1415, 16'h0004);

    bus.InstrReady = 1'b0;
    bus.Redirect   = 1'b0;
    bus.RedirectPC = 16'h0000;
    bus.Halt       = 1'b0;
    ResetN         = 1'b0;
    repeat (2) @(negedge Clock);
    chk("reset_rden",  16'(bus.MemRdEn), 16'h0);
    chk("reset_valid", 16'(bus.InstrValid), 16'h0);
    chk("reset_addr",  bus.MemAddr, 16'h0000);
    chk("reset_instr", bus.Instruction, 16'h0000);
    chk("reset_ipc",   bus.InstrPC, 16'h0000);
    chk("reset_fault", 16'(bus.Fault), 16'h0);
    ResetN = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (i > 0) @(negedge Clock);
      chk($sformatf("row%0d_rden", i),  16'(bus.MemRdEn), 16'(tbl[i].rden));
      chk($sformatf("row%0d_addr", i),  bus.MemAddr, tbl[i].addr);
      chk($sformatf("row%0d_valid", i), 16'(bus.InstrValid), 16'(tbl[i].valid));
      chk($sformatf("row%0d_instr", i), bus.Instruction, tbl[i].instr);
      chk($sformatf("row%0d_ipc", i),   bus.InstrPC, tbl[i].ipc);
      chk($sformatf("row%0d_fault", i), 16'(bus.Fault), 16'h0);
      bus.InstrReady = tbl[i].ready;
      bus.Redirect   = tbl[i].redir;
      bus.RedirectPC = tbl[i].rpc;
      bus.Halt       = tbl[i].halt;
    end

    // Reset pulse in the capture cycle of the fetch at 0x0006.
    @(negedge Clock);
    @(negedge Clock);
    chk("cap_addr", bus.MemAddr, 16'h0006);
    ResetN = 1'b0;
    #1;
    chk("midreset_instr", bus.Instruction, 16'h0000);
    chk("midreset_ipc",   bus.InstrPC, 16'h0000);
    chk("midreset_valid", 16'(bus.InstrValid), 16'h0);
    chk("midreset_rden",  16'(bus.MemRdEn), 16'h0);
    chk("midreset_addr",  bus.MemAddr, 16'h0000);
    @(negedge Clock);
    ResetN = 1'b1;
    chk("restart_idle_rden", 16'(bus.MemRdEn), 16'h0);
    @(negedge Clock);
    chk("restart_hi_rden", 16'(bus.MemRdEn), 16'h1);
    chk("restart_hi_addr", bus.MemAddr, 16'h0000);
    repeat (3) @(negedge Clock);
    chk("restart_valid", 16'(bus.InstrValid), 16'h1);
    chk("restart_instr", bus.Instruction, 16'h1234);
    chk("restart_ipc",   bus.InstrPC, 16'h0000);

`ifdef IFETCH_BOUND_CHECK_EN
    bus.Redirect = 1'b1;
    bus.RedirectPC = 16'h007E;
    @(negedge Clock);
    bus.Redirect = 1'b0;
    chk("bnd_7e_rden", 16'(bus.MemRdEn), 16'h1);
    chk("bnd_7e_addr", bus.MemAddr, 16'h007E);
    repeat (3) @(negedge Clock);
    chk("bnd_7e_valid", 16'(bus.InstrValid), 16'h1);
    chk("bnd_7e_instr", bus.Instruction, 16'h8E8F);
    chk("bnd_7e_fault", 16'(bus.Fault), 16'h0);
    bus.Redirect = 1'b1;
    bus.RedirectPC = 16'h0080;
    @(negedge Clock);
    bus.Redirect = 1'b0;
    chk("bnd_80_hi_rden", 16'(bus.MemRdEn), 16'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      chk("bnd_80_fault", 16'(bus.Fault), 16'h1);
      chk("bnd_80_rden",  16'(bus.MemRdEn), 16'h0);
      chk("bnd_80_valid", 16'(bus.InstrValid), 16'h0);
    end
    bus.Redirect = 1'b1;
    bus.RedirectPC = 16'h0000;
    @(negedge Clock);
    bus.Redirect = 1'b0;
    chk("bnd_clr_fault", 16'(bus.Fault), 16'h0);
    chk("bnd_clr_rden",  16'(bus.MemRdEn), 16'h1);
    chk("bnd_clr_addr",  bus.MemAddr, 16'h0000);
`endif

    // Randomised run against a fetch-stream model: instructions must come out in
    // program order from the model PC, honouring redirects, halts and stalls.
    ResetN = 1'b0;
    bus.Redirect = 1'b0;
    bus.Halt = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    @(negedge Clock);
    ResetN = 1'b1;
    exp_pc = 16'h0000;
    halted = 1'b0;
    after_redir = 1'b0;
    hold = 1'b0;
    prev_instr = 16'h0;
    prev_ipc = 16'h0;
    n_hs = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_fault", 16'(bus.Fault), 16'h0);
      nx = exp_pc + 16'd1;
      ok = !bus.MemRdEn || bus.MemAddr == exp_pc || bus.MemAddr == nx;
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("FAIL rnd_rd_addr: got %h expected %h or %h at %0t", bus.MemAddr, exp_pc, nx, $time);
      end
      if (halted) begin
        chk("rnd_halt_rden",  16'(bus.MemRdEn), 16'h0);
        chk("rnd_halt_valid", 16'(bus.InstrValid), 16'h0);
      end
      if (after_redir) chk("rnd_redir_valid", 16'(bus.InstrValid), 16'h0);
      if (hold) begin
        chk("rnd_hold_valid", 16'(bus.InstrValid), 16'h1);
        chk("rnd_hold_instr", bus.Instruction, prev_instr);
        chk("rnd_hold_ipc",   bus.InstrPC, prev_ipc);
      end
      if (bus.InstrValid) begin
        chk("rnd_ipc",   bus.InstrPC, exp_pc);
        chk("rnd_instr", bus.Instruction, word_at(exp_pc));
      end
      r   = ($urandom_range(0, 3) != 0);
      rd  = ((c > 0) && ($urandom_range(0, 15) == 0)) || (exp_pc >= 16'h0070);
      rpc = 16'($urandom_range(0, 16'h6F));
      h   = (c > 0) && ($urandom_range(0, 9) < 2);
      bus.InstrReady = r;
      bus.Redirect   = rd;
      bus.RedirectPC = rpc;
      bus.Halt       = h;
      hs          = bus.InstrValid && r && !rd;
      hold        = bus.InstrValid && !r && !rd;
      prev_instr  = bus.Instruction;
      prev_ipc    = bus.InstrPC;
      after_redir = rd;
      if (rd) begin
        exp_pc = rpc & 16'hFFFE;
        halted = halted || h;
      end else if (hs) begin
        exp_pc = exp_pc + 16'd2;
        halted = h;
        n_hs++;
      end else if (halted && !h) begin
        halted = 1'b0;
      end
      @(negedge Clock);
    end
    chk("rnd_progress", 16'(n_hs >= 150), 16'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_controller.md
INSTRUCTION_FETCH_CONTROLLER -- requirements
Module: instruction_fetch_controller

Interface
REQ-001 Parameter MEM_BYTES, default 128, SHALL give the instruction memory size in bytes.
REQ-002 Parameter RESET_PC, default 16'h0000, SHALL give the PC value loaded on reset; bit 0 SHALL be 0.
REQ-003 Clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 ResetN  in  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-005 MemAddr  out  16  SHALL be the byte address presented to the byte-wide instruction memory.
REQ-006 MemRdEn  out  1  SHALL be the read strobe; the memory returns MemRdData one cycle after a strobed address.
REQ-007 MemRdData  in  8  SHALL be the read byte.
REQ-008 Instruction  out  16  SHALL be the assembled instruction, big-endian: {byte[PC], byte[PC+1]}.
REQ-009 InstrPC  out  16  SHALL be the byte address of the instruction on Instruction.
REQ-010 InstrValid  out  1  /  InstrReady  in  1  SHALL form the valid/ready handshake to decode.
REQ-011 Redirect  in  1  /  RedirectPC  in  16  SHALL be the branch/jump request and target.
REQ-012 Halt  in  1  SHALL be the request to stop fetching.
REQ-013 Fault  out  1  SHALL flag an out-of-range fetch (see Configuration).

Function
REQ-014 The FSM SHALL have states IDLE, HI, LO, CAP, OUT, HALTED and FAULT.
REQ-015 IDLE: MemRdEn=0; next state HI, or HALTED if Halt=1.
REQ-016 HI: MemRdEn=1 and MemAddr=PC; next state LO.
REQ-017 LO: capture MemRdData as the high byte; MemRdEn=1 and MemAddr=PC+1 (16-bit wrap); next state CAP.
REQ-018 CAP: register {high byte, MemRdData} into Instruction and PC into InstrPC; next state OUT.
REQ-019 OUT: InstrValid=1 and MemRdEn=0; Instruction and InstrPC SHALL stay stable while InstrReady=0.
REQ-020 OUT with InstrReady=1: PC<=PC+2 (16-bit wrap); next state HALTED if Halt=1, else HI.
REQ-021 Latency SHALL be 3 cycles from entering HI to InstrValid=1; throughput SHALL be 1 instruction per 4 cycles at InstrReady=1.
REQ-022 Redirect=1 in any state SHALL load PC<={RedirectPC[15:1],1'b0} and discard any in-flight or held instruction.
REQ-023 After Redirect, InstrValid SHALL be 0 in the next cycle; next state SHALL be HI, or HALTED if in HALTED or Halt=1.
REQ-024 Redirect SHALL take priority over a simultaneous handshake; the discarded instruction SHALL not count as accepted.
REQ-025 Halt SHALL NOT abort a pending OUT handshake; it takes effect at the next HI decision point.
REQ-026 HALTED: MemRdEn=0 and InstrValid=0; leave to HI when Halt=0.
REQ-027 Outside HI and LO, MemRdEn SHALL be 0 and MemAddr SHALL hold PC.

Reset
REQ-028 ResetN=0 SHALL immediately force state IDLE, PC=RESET_PC and every register to 0: Instruction, InstrPC, InstrValid, MemRdEn, Fault and the high-byte register.
REQ-029 MemAddr SHALL equal RESET_PC during reset.
REQ-030 Reset asserted mid-fetch SHALL discard the partial instruction.
REQ-031 The first memory read SHALL occur in the second cycle after ResetN deasserts (IDLE, then HI).

Configuration
REQ-032 With macro IFETCH_BOUND_CHECK_EN defined, HI SHALL go to FAULT without a read when PC > MEM_BYTES-2.
REQ-033 FAULT SHALL set Fault=1, hold MemRdEn=0 and InstrValid=0, and exit only on reset or Redirect (clearing Fault).
REQ-034 Without IFETCH_BOUND_CHECK_EN, Fault SHALL be constant 0, FAULT SHALL be unreachable and addresses SHALL pass unchecked.

Verification
REQ-035 Memory bytes 0x00=0x12 and 0x01=0x34 with InstrReady=1 after reset -> Instruction=0x1234, InstrPC=0x0000; the next instruction arrives 4 cycles later at InstrPC=0x0002.
REQ-036 InstrReady=0 for 5 cycles in OUT -> InstrValid, Instruction and InstrPC stable; no MemRdEn pulses; PC advances only on release.
REQ-037 Redirect=1 with RedirectPC=0x0011 during LO -> InstrValid=0 next cycle; the next HI reads MemAddr=0x0010.
REQ-038 Halt=1 during OUT with InstrReady=1 -> one handshake completes, then HALTED with no reads; Halt=0 resumes at PC+2.
REQ-039 With IFETCH_BOUND_CHECK_EN defined and MEM_BYTES=128: Redirect to 0x007E -> normal fetch; Redirect to 0x0080 -> Fault=1 with no MemRdEn; Redirect to 0x0000 -> Fault clears.
REQ-040 ResetN pulsed low during CAP -> outputs 0 immediately; after release, the fetch restarts at RESET_PC.
